rx_delay_meter: RTL and testbench
=================================

// Module: rx_delay_meter
// PURPOSE
//  Sits beside the receive frame capture on the MAC receive interface (rx_clk domain).
//  Parses each received probe frame and extracts the 16-bit sequence number and the transmit timestamp.
//  Computes one-way delay against a free-running local timestamp, tracks sequence errors,
//  and emits one result per probe frame plus good/bad/sequence-error counters for the test controller.
// PARAMETERS
//  TS_W            32       timestamp width in bits; must be a multiple of 8, range 8..64
//  ETHERTYPE       16'h88B5 probe ethertype, compared at frame bytes 12..13
//  SEQ_OFS         14       byte index of the sequence MSB; sequence occupies 2 bytes, big-endian
//  TS_OFS          16       byte index of the tx timestamp MSB; timestamp occupies TS_W/8 bytes, big-endian
//  STATUS_TIMEOUT  16       cycles to wait after dvld falls for a goodframe/badframe pulse
// PORTS
//  rx_clk           in   1     receive clock; all logic on the rising edge
//  reset            in   1     asynchronous, active-high reset
//  mac_rx_data      in   8     receive byte; valid when mac_rx_dvld=1
//  mac_rx_dvld      in   1     byte valid; high for the contiguous bytes of one frame
//  mac_rx_goodframe in   1     1-cycle pulse after the frame: CRC/length good
//  mac_rx_badframe  in   1     1-cycle pulse after the frame: frame bad
//  timestamp        in   TS_W  free-running local time, same clock
//  result_valid     out  1     1-cycle pulse: result_* fields are valid
//  result_seq       out  16    sequence number of the reported frame
//  result_delay     out  TS_W  rx_ts - tx_ts, modulo 2^TS_W
//  result_ok        out  1     1 = frame good and in-sequence
//  cnt_good         out  16    count of good probe frames, saturating
//  cnt_bad          out  16    count of bad, short or timed-out probe frames, saturating
//  cnt_seq_err      out  16    count of good probe frames with an unexpected sequence number, saturating
// BEHAVIOUR
//  Reset: all outputs 0 and state SKIP. All counters, the byte counter and the captured fields are cleared.
//  States: SKIP, IDLE, DATA, WAIT_ST, REPORT.
//   SKIP    -> IDLE when dvld=0. This discards a frame that is partly received when reset is released.
//   IDLE    -> DATA when dvld=1. On that cycle, byte 0 is taken and rx_ts<=timestamp is captured.
//   DATA    -> WAIT_ST when dvld=0. A 14-bit byte counter increments on each byte and saturates at 16383.
//   WAIT_ST -> REPORT on goodframe or badframe. The status is sampled in that cycle.
//   WAIT_ST -> REPORT on timeout: STATUS_TIMEOUT cycles pass with no status pulse. The frame is treated as bad.
//   WAIT_ST with dvld=1 before any status: the pending frame is treated as bad (counted only if it matched)
//   and never reported; the new frame starts (goes to DATA, takes byte 0 and captures rx_ts).
//   REPORT  -> IDLE after 1 cycle. If dvld=1 in this cycle, go straight to DATA and take byte 0.
//  Field capture:
//   - Ethertype match requires byte12==ETHERTYPE[15:8] and byte13==ETHERTYPE[7:0].
//   - The sequence number and tx_ts are shifted in MSB first.
//   - A frame is short if fewer than TS_OFS+TS_W/8 bytes arrive.
//  Frames with no ethertype match (including frames under 14 bytes) are ignored entirely.
//  They produce no result and change no counter.
//  The status pulse is taken into account only in WAIT_ST. goodframe and badframe together count as bad.
//  In REPORT, for a matched frame only:
//   - result_valid=1. result_seq and result_delay are registered; latency is 1 cycle after the status or timeout.
//   - good and not short: cnt_good+1.
//     If the sequence is primed and seq != exp_seq, also cnt_seq_err+1 and result_ok=0.
//     Then exp_seq <= seq+1 (wraps 0xFFFF->0) and the primed flag is set.
//   - bad, short or timeout: cnt_bad+1 and result_ok=0. exp_seq is unchanged.
//  The first good frame after reset primes exp_seq and is never a sequence error.
//  result_delay wraps modulo 2^TS_W (tx_ts > rx_ts gives the wrapped difference).
//  result_* hold their value between pulses. Counters stay at 16'hFFFF once they reach it.
// TESTING
//  1. Probe frame of 64B with seq=5, tx_ts=100, timestamp=250 at byte 0, then goodframe
//     -> one result_valid pulse: seq=5, delay=150, ok=1; cnt_good=1.
//  2. Frames with seq 5, 6, 8, all good -> cnt_seq_err=1; third result has ok=0; exp_seq ends at 9.
//  3. tx_ts=32'hFFFF_FFF0 and rx_ts=32'h10 -> delay=32'h20.
//  4. Probe frame of 17B, then goodframe -> cnt_bad+1, ok=0.
//     Non-probe ethertype 0x0800 -> no result, no counter change.
//  5. No status pulse for 16 cycles after dvld falls -> timeout: report with ok=0, cnt_bad=1.
//     goodframe and badframe together -> counted bad.
//  6. Reset asserted at byte 20 with dvld still high after release -> state SKIP, no result;
//     the next full frame is reported normally.

Source files
------------

// File: rtl/rx_delay_meter.sv
// Probe-frame one-way delay meter on the MAC receive byte stream.
// Extracts sequence and tx timestamp, reports delay and keeps counters.
module rx_delay_meter #(
  parameter int unsigned TS_W           = 32,
  parameter logic [15:0] ETHERTYPE      = 16'h88B5,
  parameter int unsigned SEQ_OFS        = 14,
  parameter int unsigned TS_OFS         = 16,
  parameter int unsigned STATUS_TIMEOUT = 16
) (
  input  logic            rx_clk,
  input  logic            reset,
  input  logic [7:0]      mac_rx_data,
  input  logic            mac_rx_dvld,
  input  logic            mac_rx_goodframe,
  input  logic            mac_rx_badframe,
  input  logic [TS_W-1:0] timestamp,
  output logic            result_valid,
  output logic [15:0]     result_seq,
  output logic [TS_W-1:0] result_delay,
  output logic            result_ok,
  output logic [15:0]     cnt_good,
  output logic [15:0]     cnt_bad,
  output logic [15:0]     cnt_seq_err
);

  localparam logic [13:0] SEQ_LO   = 14'(SEQ_OFS);
  localparam logic [13:0] TS_LO    = 14'(TS_OFS);
  localparam logic [13:0] TS_HI    = 14'(TS_OFS + TS_W / 8);
  localparam logic [15:0] TMO_LAST = 16'(STATUS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    SKIP,
    IDLE,
    DATA,
    WAIT_ST,
    REPORT
  } state_e;

  state_e          state_q, state_d;
  logic [13:0]     bcnt_q, bcnt_d;
  logic [15:0]     tmr_q, tmr_d;
  logic            eth_hi_q, eth_hi_d;
  logic            match_q, match_d;
  logic [15:0]     seq_q, seq_d;
  logic [TS_W-1:0] txts_q, txts_d;
  logic [TS_W-1:0] rxts_q, rxts_d;
  logic [15:0]     exp_q, exp_d;
  logic            primed_q, primed_d;
  logic            rv_q, rv_d;
  logic [15:0]     rseq_q, rseq_d;
  logic [TS_W-1:0] rdly_q, rdly_d;
  logic            rok_q, rok_d;
  logic [15:0]     good_q, good_d;
  logic [15:0]     bad_q, bad_d;
  logic [15:0]     err_q, err_d;

  logic            status;
  logic            start;
  logic            take;
  logic            fin;
  logic            abort;
  logic            tmo;
  logic            bad_f;
  logic [13:0]     idx;

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign status = mac_rx_goodframe | mac_rx_badframe;

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state_q  <= SKIP;
      bcnt_q   <= '0;
      tmr_q    <= '0;
      eth_hi_q <= 1'b0;
      match_q  <= 1'b0;
      seq_q    <= '0;
      txts_q   <= '0;
      rxts_q   <= '0;
      exp_q    <= '0;
      primed_q <= 1'b0;
      rv_q     <= 1'b0;
      rseq_q   <= '0;
      rdly_q   <= '0;
      rok_q    <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      tmr_q    <= tmr_d;
      eth_hi_q <= eth_hi_d;
      match_q  <= match_d;
      seq_q    <= seq_d;
      txts_q   <= txts_d;
      rxts_q   <= rxts_d;
      exp_q    <= exp_d;
      primed_q <= primed_d;
      rv_q     <= rv_d;
      rseq_q   <= rseq_d;
      rdly_q   <= rdly_d;
      rok_q    <= rok_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    tmr_d    = tmr_q;
    eth_hi_d = eth_hi_q;
    match_d  = match_q;
    seq_d    = seq_q;
    txts_d   = txts_q;
    rxts_d   = rxts_q;
    exp_d    = exp_q;
    primed_d = primed_q;
    rv_d     = 1'b0;
    rseq_d   = rseq_q;
    rdly_d   = rdly_q;
    rok_d    = rok_q;
    good_d   = good_q;
    bad_d    = bad_q;
    err_d    = err_q;
    start    = 1'b0;
    take     = 1'b0;
    fin      = 1'b0;
    abort    = 1'b0;
    tmo      = 1'b0;

    unique case (state_q)
      SKIP: begin
        if (!mac_rx_dvld) state_d = IDLE;
      end
      IDLE: begin
        if (mac_rx_dvld) start = 1'b1;
      end
      DATA: begin
        if (mac_rx_dvld) begin
          take = 1'b1;
        end else begin
          state_d = WAIT_ST;
          tmr_d   = '0;
        end
      end
      WAIT_ST: begin
        if (status) begin
          fin = 1'b1;
        end else if (mac_rx_dvld) begin
          abort = 1'b1;
          start = 1'b1;
        end else if (tmr_q == TMO_LAST) begin
          fin = 1'b1;
          tmo = 1'b1;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      REPORT: begin
        state_d = IDLE;
        if (mac_rx_dvld) start = 1'b1;
      end
      default: state_d = SKIP;
    endcase

    // Byte 0 of a new frame can arrive from IDLE, WAIT_ST or REPORT.
    idx = start ? '0 : bcnt_q;
    if (start) begin
      state_d  = DATA;
      bcnt_d   = 14'd1;
      eth_hi_d = 1'b0;
      match_d  = 1'b0;
      rxts_d   = timestamp;
    end else if (take) begin
      bcnt_d = (bcnt_q == '1) ? bcnt_q : bcnt_q + 14'd1;
    end

    if (start || take) begin
      if (idx == 14'd12)
        eth_hi_d = (mac_rx_data == ETHERTYPE[15:8]);
      if (idx == 14'd13)
        match_d = eth_hi_q && (mac_rx_data == ETHERTYPE[7:0]);
      if (idx == SEQ_LO || idx == SEQ_LO + 14'd1)
        seq_d = {seq_q[7:0], mac_rx_data};
      if (idx >= TS_LO && idx < TS_HI)
        txts_d = (txts_q << 8) | TS_W'(mac_rx_data);
    end

    bad_f = tmo | mac_rx_badframe | ~mac_rx_goodframe |
            (bcnt_q < TS_HI);

    if (fin) begin
      state_d = REPORT;
      if (match_q) begin
        rv_d   = 1'b1;
        rseq_d = seq_q;
        rdly_d = rxts_q - txts_q;
        if (bad_f) begin
          bad_d = sat16(bad_q);
          rok_d = 1'b0;
        end else begin
          good_d = sat16(good_q);
          rok_d  = 1'b1;
          if (primed_q && seq_q != exp_q) begin
            err_d = sat16(err_q);
            rok_d = 1'b0;
          end
          exp_d    = seq_q + 16'd1;
          primed_d = 1'b1;
        end
      end
    end

    // A frame overrun by the next one is bad and never reported.
    if (abort && match_q) bad_d = sat16(bad_q);
  end

  assign result_valid = rv_q;
  assign result_seq   = rseq_q;
  assign result_delay = rdly_q;
  assign result_ok    = rok_q;
  assign cnt_good     = good_q;
  assign cnt_bad      = bad_q;
  assign cnt_seq_err  = err_q;

endmodule

// File: tb/tb_rx_delay_meter.sv
// Bench for rx_delay_meter: directed table, hand sequences
// and random frames against a frame-level reference model.
module tb_rx_delay_meter;

  localparam logic [15:0] ET = 16'h88B5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data = '0;
  logic        dvld = 1'b0;
  logic        good = 1'b0;
  logic        bad = 1'b0;
  logic [31:0] ts = '0;
  logic        rv;
  logic [15:0] rseq;
  logic [31:0] rdly;
  logic        rok;
  logic [15:0] cg, cb, ce;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;

  typedef struct {
    logic [15:0] seq;
    logic [31:0] dly;
    logic        ok;
    int          cyc;
    bit          cs;
    bit          cd;
  } res_t;

  res_t obs_q[$];
  res_t exp_q[$];

  logic [15:0] m_good = '0;
  logic [15:0] m_bad = '0;
  logic [15:0] m_err = '0;
  logic [15:0] m_exp = '0;
  bit          m_primed = 1'b0;

  typedef struct {
    int          len;
    logic [15:0] et;
    logic [15:0] seq;
    logic [31:0] tx;
    logic [31:0] rx;
    int          kind;
    bit          v;
    logic [31:0] d;
    bit          ok;
    logic [15:0] g;
    logic [15:0] b;
    logic [15:0] e;
  } vec_t;

  vec_t tv[13];

  rx_delay_meter dut (
    .rx_clk           (clk),
    .reset            (rst),
    .mac_rx_data      (data),
    .mac_rx_dvld      (dvld),
    .mac_rx_goodframe (good),
    .mac_rx_badframe  (bad),
    .timestamp        (ts),
    .result_valid     (rv),
    .result_seq       (rseq),
    .result_delay     (rdly),
    .result_ok        (rok),
    .cnt_good         (cg),
    .cnt_bad          (cb),
    .cnt_seq_err      (ce)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // One cycle: sample outputs of the previous cycle, then drive.
  task automatic drive(input logic dv, input logic [7:0] d,
                       input logic g, input logic b);
    res_t r;
    @(negedge clk);
    ncyc++;
    if (rv === 1'b1) begin
      r.seq = rseq;
      r.dly = rdly;
      r.ok  = rok;
      r.cyc = ncyc;
      r.cs  = 1'b1;
      r.cd  = 1'b1;
      obs_q.push_back(r);
    end
    dvld = dv;
    data = d;
    good = g;
    bad  = b;
    ts   = ts + 32'd1;
  endtask

  // kind: 0 good, 1 bad, 2 good+bad, 3 no status, 4 overrun by next frame
  task automatic send_frame(input int len, input logic [15:0] et,
                            input logic [15:0] seq, input logic [31:0] tx,
                            input logic [31:0] rx, input int kind,
                            input int gap, input bit b2b);
    logic [7:0] fb [0:127];
    bit   matched, shrt, isbad;
    int   st_call;
    res_t e;
    for (int i = 0; i < 128; i++) fb[i] = 8'($urandom);
    fb[12] = et[15:8];
    fb[13] = et[7:0];
    fb[14] = seq[15:8];
    fb[15] = seq[7:0];
    fb[16] = tx[31:24];
    fb[17] = tx[23:16];
    fb[18] = tx[15:8];
    fb[19] = tx[7:0];
    for (int i = 0; i < len; i++) begin
      drive(1'b1, fb[i], 1'b0, 1'b0);
      if (i == 0) ts = rx;
    end
    matched = (len >= 14) && (et == ET);
    shrt    = (len < 20);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    if (kind == 4) begin
      if (matched) m_bad = sat(m_bad);
      return;
    end
    if (kind == 3) begin
      repeat (16) drive(1'b0, 8'h00, 1'b0, 1'b0);
    end else begin
      repeat (gap) drive(1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 8'h00, kind == 0 || kind == 2, kind == 1 || kind == 2);
    end
    st_call = ncyc;
    if (matched) begin
      isbad = (kind != 0) || shrt;
      e.seq = seq;
      e.dly = rx - tx;
      e.cyc = st_call + 1;
      e.cs  = (len >= 16);
      e.cd  = (len >= 20);
      if (isbad) begin
        m_bad = sat(m_bad);
        e.ok  = 1'b0;
      end else begin
        m_good = sat(m_good);
        e.ok   = 1'b1;
        if (m_primed && seq != m_exp) begin
          m_err = sat(m_err);
          e.ok  = 1'b0;
        end
        m_exp    = seq + 16'd1;
        m_primed = 1'b1;
      end
      exp_q.push_back(e);
    end
    if (!b2b) repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic cmp_results(input string tag);
    res_t o, e;
    chk({tag, "_nres"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (e.cs) chk({tag, "_seq"}, {16'h0, o.seq}, {16'h0, e.seq});
      if (e.cd) chk({tag, "_delay"}, o.dly, e.dly);
      chk({tag, "_ok"}, {31'h0, o.ok}, {31'h0, e.ok});
      chk({tag, "_lat"}, 32'(o.cyc), 32'(e.cyc));
    end
    obs_q.delete();
    exp_q.delete();
    chk({tag, "_cnt_good"}, {16'h0, cg}, {16'h0, m_good});
    chk({tag, "_cnt_bad"}, {16'h0, cb}, {16'h0, m_bad});
    chk({tag, "_cnt_seq_err"}, {16'h0, ce}, {16'h0, m_err});
  endtask

  initial begin
    res_t o, e;
    int   len, kind, gap, k;
    bit   b2b;
    logic [15:0] et, seq;

    tv[0]  = '{64, ET, 16'd5, 32'd100, 32'd250, 0,
               1'b1, 32'd150, 1'b1, 16'd1, 16'd0, 16'd0};
    tv[1]  = '{64, ET, 16'd6, 32'd1000, 32'd1010, 0,
               1'b1, 32'd10, 1'b1, 16'd2, 16'd0, 16'd0};
    tv[2]  = '{64, ET, 16'd8, 32'd0, 32'd7, 0,
               1'b1, 32'd7, 1'b0, 16'd3, 16'd0, 16'd1};
    tv[3]  = '{64, ET, 16'd9, 32'hFFFF_FFF0, 32'h10, 0,
               1'b1, 32'h20, 1'b1, 16'd4, 16'd0, 16'd1};
    tv[4]  = '{17, ET, 16'd10, 32'd0, 32'd0, 0,
               1'b1, 32'd0, 1'b0, 16'd4, 16'd1, 16'd1};
    tv[5]  = '{64, 16'h0800, 16'd10, 32'd0, 32'd5, 0,
               1'b0, 32'd0, 1'b0, 16'd4, 16'd1, 16'd1};
    tv[6]  = '{64, ET, 16'd10, 32'd500, 32'd600, 3,
               1'b1, 32'd100, 1'b0, 16'd4, 16'd2, 16'd1};
    tv[7]  = '{64, ET, 16'd10, 32'd1, 32'd3, 2,
               1'b1, 32'd2, 1'b0, 16'd4, 16'd3, 16'd1};
    tv[8]  = '{64, ET, 16'd10, 32'd2, 32'd9, 1,
               1'b1, 32'd7, 1'b0, 16'd4, 16'd4, 16'd1};
    tv[9]  = '{64, ET, 16'd10, 32'd40, 32'd41, 0,
               1'b1, 32'd1, 1'b1, 16'd5, 16'd4, 16'd1};
    tv[10] = '{13, ET, 16'd0, 32'd0, 32'd0, 0,
               1'b0, 32'd0, 1'b0, 16'd5, 16'd4, 16'd1};
    tv[11] = '{20, ET, 16'd11, 32'd5, 32'd6, 0,
               1'b1, 32'd1, 1'b1, 16'd6, 16'd4, 16'd1};
    tv[12] = '{19, ET, 16'd12, 32'd0, 32'd0, 0,
               1'b1, 32'd0, 1'b0, 16'd6, 16'd5, 16'd1};

    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_valid", {31'h0, rv}, 32'd0);
    chk("rst_seq", {16'h0, rseq}, 32'd0);
    chk("rst_delay", rdly, 32'd0);
    chk("rst_ok", {31'h0, rok}, 32'd0);
    chk("rst_cnt_good", {16'h0, cg}, 32'd0);
    chk("rst_cnt_bad", {16'h0, cb}, 32'd0);
    chk("rst_cnt_seq_err", {16'h0, ce}, 32'd0);
    rst = 1'b0;
    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      send_frame(tv[i].len, tv[i].et, tv[i].seq, tv[i].tx, tv[i].rx,
                 tv[i].kind, 1, 1'b0);
      chk("tv_nres", 32'(obs_q.size()), {31'h0, tv[i].v});
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        if (tv[i].len >= 16)
          chk("tv_seq", {16'h0, o.seq}, {16'h0, tv[i].seq});
        if (tv[i].len >= 20) chk("tv_delay", o.dly, tv[i].d);
        chk("tv_ok", {31'h0, o.ok}, {31'h0, tv[i].ok});
        chk("tv_lat", 32'(o.cyc), 32'(e.cyc));
      end
      chk("tv_cnt_good", {16'h0, cg}, {16'h0, tv[i].g});
      chk("tv_cnt_bad", {16'h0, cb}, {16'h0, tv[i].b});
      chk("tv_cnt_seq_err", {16'h0, ce}, {16'h0, tv[i].e});
      obs_q.delete();
      exp_q.delete();
    end

    // Status-less frame overrun by the next frame.
    send_frame(64, ET, 16'd12, 32'd5, 32'd9, 4, 1, 1'b0);
    send_frame(64, ET, 16'd12, 32'd3, 32'd8, 0, 1, 1'b0);
    chk("abort_cnt_bad", {16'h0, cb}, 32'd6);
    chk("abort_cnt_good", {16'h0, cg}, 32'd7);
    cmp_results("abort");

    // Next frame starts in the REPORT cycle.
    send_frame(64, ET, 16'd13, 32'd100, 32'd130, 0, 0, 1'b1);
    send_frame(64, ET, 16'd14, 32'd7, 32'd7, 0, 2, 1'b0);
    chk("b2b_cnt_good", {16'h0, cg}, 32'd9);
    cmp_results("b2b");

    // Reset in mid-frame with dvld still high after release.
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, (i == 12) ? 8'h88 : (i == 13) ? 8'hB5 : 8'(i),
            1'b0, 1'b0);
      if (i == 20) rst = 1'b1;
      if (i == 22) rst = 1'b0;
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
    m_good = '0;
    m_bad = '0;
    m_err = '0;
    m_exp = '0;
    m_primed = 1'b0;
    exp_q.delete();
    cmp_results("midrst");
    send_frame(64, ET, 16'd300, 32'd10, 32'd20, 0, 1, 1'b0);
    chk("midrst_next_good", {16'h0, cg}, 32'd1);
    cmp_results("midrst_next");

    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(70, 10);
      et  = ($urandom_range(4, 0) == 0) ? 16'h0800 : ET;
      seq = ($urandom_range(2, 0) == 0) ? 16'($urandom) : m_exp;
      k   = $urandom_range(7, 0);
      kind = (k < 4) ? 0 : k - 3;
      if (i == 39 && kind == 4) kind = 0;
      gap = $urandom_range(4, 0);
      b2b = (kind != 4) && ($urandom_range(3, 0) == 0);
      send_frame(len, et, seq, $urandom, $urandom, kind, gap, b2b);
    end
    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
    cmp_results("rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
